wb_align_stage: RTL and testbench
=================================

# wb_align_stage

Parametrised, registered writeback stage for the SPARC integer pipeline, sitting between the memory stage and the register file / Y / icc state. It aligns and extends load data by byte offset (big-endian), suppresses writes to %g0, and splits LDD into two sequential single-register writes with back-pressure on the memory stage. All outputs are registered: one cycle of latency from accepted input to writeback strobe.

## Interface
Parameters:
- DATA_W, 32, register/data width; legal values 32 or 64
- RD_W, 5, destination register index width
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready
- in_op  in  2  SPARC op field; 2'b11 = load/store class
- in_op3  in  6  SPARC op3 field
- in_rd  in  RD_W  destination register
- in_reg_write  in  1  instruction writes rd
- in_alures  in  DATA_W  ALU result
- in_load_data  in  2*DATA_W  load data; [DATA_W-1:0] = aligned word for single loads; LDD: upper half → even rd, lower half → rd+1
- in_addr_lo  in  OFF_W  low address bits of the load
- in_y_write / in_y_data  in  1 / DATA_W  Y register update
- in_icc_write / in_icc  in  1 / 4  condition-code update
- wb_reg_en  out  1  register-file write strobe
- wb_rd  out  RD_W  write index
- wb_data  out  DATA_W  write data
- wb_y_en / wb_y_data  out  1 / DATA_W  Y write
- wb_icc_en / wb_icc  out  1 / 4  icc write

## Operation
- States: IDLE (no pending work), LDD2 (second LDD word pending).
- IDLE: in_ready=1. On transfer, outputs register the instruction's writes; non-transfer cycles clear all *_en outputs.
- Data select when in_op==2'b11 and op3 is a load: LDSB 6'b001001, LDSH 6'b001010 sign-extend; LDUB 6'b000001, LDUH 6'b000010 zero-extend; LD 6'b000000 zero-extends a 32-bit word; LDD 6'b000011. Otherwise wb_data = in_alures.
- Big-endian lanes: byte offset k selects bits [DATA_W-1-8k -: 8]; halfword uses in_addr_lo with bit 0 ignored; LD uses in_addr_lo[OFF_W-1:2] (constant 0 when DATA_W=32), bits [1:0] ignored.
- LDD: rd forced even (in_rd & ~1). Cycle 1 writes even rd with upper half; state → LDD2, in_ready=0; second half and rd|1 latched internally. LDD2: writes rd|1 with lower half, returns to IDLE, in_ready=1.
- %g0: wb_reg_en forced 0 whenever the write index is 0; wb_y_en/wb_icc_en unaffected. LDD with rd=0 still performs the rd=1 write.
- Y/icc pass through with the instruction's first writeback cycle only; never asserted in LDD2.

## Timing
- Reset (async assert): state IDLE, in_ready=1 after reset, all wb_* outputs 0.
- Latency 1 cycle from transfer edge to wb_* valid; each strobe high exactly one cycle per write.
- in_ready is combinational from state only (never from in_valid).
- Reset asserted in LDD2 discards the pending second word; no write occurs.
- Back-to-back transfers in IDLE sustain one write per cycle; LDD costs 2 cycles.

## Configuration
- WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_rd (RD_W), fwd_data (DATA_W), equal to wb_reg_en/wb_rd/wb_data of the previous cycle (one extra register stage, reset 0) for the decode-stage bypass. Undefined: ports absent, no extra registers.

## Test plan
- LDUB, in_load_data[31:0]=0x8A1B2C3D, in_addr_lo=0, rd=3 → next cycle wb_reg_en=1, wb_rd=3, wb_data=0x0000008A.
- LDSH, same data, in_addr_lo=2 (and 3) → wb_data=0x00002C3D; with data 0x1234F00D, addr_lo=2 → 0xFFFFF00D.
- LDD rd=5, data 0xAAAA5555_11112222 → cycle 1: rd=4, 0xAAAA5555, in_ready=0; cycle 2: rd=5, 0x11112222; in_ready=1 after.
- ADD with rd=0, icc write 4'b0100 → wb_reg_en=0, wb_icc_en=1, wb_icc=4'b0100.
- Reset asserted during LDD2 → all outputs 0 immediately, no rd+1 write, in_ready=1 after release.
- WB_FWD_EN build: three back-to-back ALU writes → fwd_* trails wb_* by exactly one cycle.

Source files
------------

// File: rtl/wb_align_stage.sv
`default_nettype none
// wb_align_stage: registered SPARC writeback stage (big-endian load alignment, %g0 suppression, LDD split).
// Define WB_FWD_EN to add fwd_valid/fwd_rd/fwd_data, a one-cycle-delayed copy of the register write.
module wb_align_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [5:0]          in_op3,
   input  logic [RD_W-1:0]     in_rd,
   input  logic                in_reg_write,
   input  logic [DATA_W-1:0]   in_alures,
   input  logic [2*DATA_W-1:0] in_load_data,
   input  logic [OFF_W-1:0]    in_addr_lo,
   input  logic                in_y_write,
   input  logic [DATA_W-1:0]   in_y_data,
   input  logic                in_icc_write,
   input  logic [3:0]          in_icc,
   output logic                wb_reg_en,
   output logic [RD_W-1:0]     wb_rd,
   output logic [DATA_W-1:0]   wb_data,
   output logic                wb_y_en,
   output logic [DATA_W-1:0]   wb_y_data,
   output logic                wb_icc_en,
   output logic [3:0]          wb_icc
`ifdef WB_FWD_EN
   ,
   output logic                fwd_valid,
   output logic [RD_W-1:0]     fwd_rd,
   output logic [DATA_W-1:0]   fwd_data
`endif
);

   localparam int NB = DATA_W/8;

   localparam logic [5:0] OP3_LD   = 6'b000000;
   localparam logic [5:0] OP3_LDUB = 6'b000001;
   localparam logic [5:0] OP3_LDUH = 6'b000010;
   localparam logic [5:0] OP3_LDD  = 6'b000011;
   localparam logic [5:0] OP3_LDSB = 6'b001001;
   localparam logic [5:0] OP3_LDSH = 6'b001010;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LDD2 = 1'b1
   } state_t;

   state_t            state_q;
   logic [RD_W-1:0]   pend_rd_q;
   logic [DATA_W-1:0] pend_data_q;
   logic              pend_we_q;

   logic              xfer_d;
   logic              is_ldd_d;
   logic [RD_W-1:0]   rd_d;
   logic [DATA_W-1:0] word_d;
   logic [DATA_W-1:0] data_d;
   logic [7:0]        byte_d;
   logic [15:0]       half_d;
   logic [31:0]       w32_d;
   int                kb_d;
   int                kh_d;
   int                kw_d;

   assign in_ready = (state_q == S_IDLE);

   // Byte lane k sits at bits [DATA_W-1-8k -: 8]; shift it down to the LSBs.
   always_comb begin
      xfer_d   = in_valid && in_ready;
      word_d   = in_load_data[DATA_W-1:0];
      kb_d     = int'(in_addr_lo);
      kh_d     = kb_d & ~1;
      kw_d     = kb_d & ~3;
      byte_d   = 8'(word_d >> (8*(NB-1-kb_d)));
      half_d   = 16'(word_d >> (8*(NB-2-kh_d)));
      w32_d    = 32'(word_d >> (8*(NB-4-kw_d)));
      is_ldd_d = (in_op == 2'b11) && (in_op3 == OP3_LDD);
      rd_d     = is_ldd_d ? (in_rd & ~RD_W'(1)) : in_rd;
      data_d   = in_alures;
      if (in_op == 2'b11) begin
         case (in_op3)
            OP3_LDSB: data_d = {{(DATA_W-8){byte_d[7]}}, byte_d};
            OP3_LDSH: data_d = {{(DATA_W-16){half_d[15]}}, half_d};
            OP3_LDUB: data_d = DATA_W'(byte_d);
            OP3_LDUH: data_d = DATA_W'(half_d);
            OP3_LD:   data_d = DATA_W'(w32_d);
            OP3_LDD:  data_d = in_load_data[2*DATA_W-1:DATA_W];
            default:  data_d = in_alures;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pend_rd_q   <= '0;
         pend_data_q <= '0;
         pend_we_q   <= 1'b0;
         wb_reg_en   <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wb_y_en     <= 1'b0;
         wb_y_data   <= '0;
         wb_icc_en   <= 1'b0;
         wb_icc      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               wb_reg_en <= xfer_d && in_reg_write && (rd_d != '0);
               wb_y_en   <= xfer_d && in_y_write;
               wb_icc_en <= xfer_d && in_icc_write;
               if (xfer_d) begin
                  wb_rd     <= rd_d;
                  wb_data   <= data_d;
                  wb_y_data <= in_y_data;
                  wb_icc    <= in_icc;
                  if (is_ldd_d) begin
                     state_q     <= S_LDD2;
                     pend_rd_q   <= rd_d | RD_W'(1);
                     pend_data_q <= in_load_data[DATA_W-1:0];
                     pend_we_q   <= in_reg_write;
                  end
               end
            end
            S_LDD2: begin
               // rd|1 is never %g0, so only the instruction's own write enable matters.
               wb_reg_en <= pend_we_q;
               wb_rd     <= pend_rd_q;
               wb_data   <= pend_data_q;
               wb_y_en   <= 1'b0;
               wb_icc_en <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef WB_FWD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_valid <= 1'b0;
         fwd_rd    <= '0;
         fwd_data  <= '0;
      end else begin
         fwd_valid <= wb_reg_en;
         fwd_rd    <= wb_rd;
         fwd_data  <= wb_data;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_align_stage.sv
`default_nettype none
// tb_wb_align_stage: directed and randomized checks of wb_align_stage against a byte-list behavioural model.
module tb_wb_align_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid, in_ready, in_reg_write, in_y_write, in_icc_write;
   logic [1:0]  in_op;
   logic [5:0]  in_op3;
   logic [4:0]  in_rd;
   logic [31:0] in_alures, in_y_data;
   logic [63:0] in_load_data;
   logic [1:0]  in_addr_lo;
   logic [3:0]  in_icc;
   logic        wb_reg_en, wb_y_en, wb_icc_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, wb_y_data;
   logic [3:0]  wb_icc;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   wb_align_stage #(.DATA_W(32), .RD_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_op3(in_op3), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_alures(in_alures), .in_load_data(in_load_data), .in_addr_lo(in_addr_lo),
      .in_y_write(in_y_write), .in_y_data(in_y_data),
      .in_icc_write(in_icc_write), .in_icc(in_icc),
      .wb_reg_en(wb_reg_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_y_en(wb_y_en), .wb_y_data(wb_y_data),
      .wb_icc_en(wb_icc_en), .wb_icc(wb_icc)
`ifdef WB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: pending second LDD word plus the expected outputs after the coming edge.
   bit          m_pend;
   int          p_rd;
   logic [31:0] p_data;
   bit          e_ren, e_yen, e_ien;
   int          e_rd;
   logic [31:0] e_data, e_yd;
   logic [3:0]  e_icc;
   bit          f_ren;
   int          f_rd;
   logic [31:0] f_data;

   logic [5:0]  codes [6] = '{6'b001001, 6'b001010, 6'b000001, 6'b000010, 6'b000000, 6'b000011};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] model_data(input logic [1:0] op, input logic [5:0] op3,
                                              input logic [31:0] alu, input logic [63:0] ld, input int k);
      int     b [4];
      longint v;
      int     h;
      int     s;
      v = longint'(ld[31:0]);
      for (int i = 3; i >= 0; i--) begin
         b[i] = int'(v % 256);
         v    = v / 256;
      end
      h = b[k - k%2]*256 + b[k - k%2 + 1];
      if (op != 2'b11) return alu;
      case (op3)
         6'b001001: begin s = b[k]; if (s >= 128) s -= 256; return 32'(s); end
         6'b001010: begin s = h; if (s >= 32768) s -= 65536; return 32'(s); end
         6'b000001: return 32'(b[k]);
         6'b000010: return 32'(h);
         6'b000000: return ld[31:0];
         6'b000011: return ld[63:32];
         default:   return alu;
      endcase
   endfunction

   task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] op3, input int rd, input bit rw,
                        input logic [31:0] alu, input logic [63:0] ld, input int addr,
                        input bit yw, input logic [31:0] yd, input bit iw, input logic [3:0] icc);
      in_valid = v; in_op = op; in_op3 = op3; in_rd = 5'(rd); in_reg_write = rw;
      in_alures = alu; in_load_data = ld; in_addr_lo = 2'(addr);
      in_y_write = yw; in_y_data = yd; in_icc_write = iw; in_icc = icc;
   endtask

   task automatic compare();
      chk("in_ready", 64'(in_ready), 64'(!m_pend));
      chk("wb_reg_en", 64'(wb_reg_en), 64'(e_ren));
      if (e_ren) begin
         chk("wb_rd", 64'(wb_rd), 64'(e_rd));
         chk("wb_data", 64'(wb_data), 64'(e_data));
      end
      chk("wb_y_en", 64'(wb_y_en), 64'(e_yen));
      if (e_yen) chk("wb_y_data", 64'(wb_y_data), 64'(e_yd));
      chk("wb_icc_en", 64'(wb_icc_en), 64'(e_ien));
      if (e_ien) chk("wb_icc", 64'(wb_icc), 64'(e_icc));
`ifdef WB_FWD_EN
      chk("fwd_valid", 64'(fwd_valid), 64'(f_ren));
      if (f_ren) begin
         chk("fwd_rd", 64'(fwd_rd), 64'(f_rd));
         chk("fwd_data", 64'(fwd_data), 64'(f_data));
      end
`endif
   endtask

   // Called just after a falling edge with inputs applied; advances the model over the next rising edge.
   task automatic step();
      bit ldd;
      int rd;
      f_ren = e_ren; f_rd = e_rd; f_data = e_data;
      if (m_pend) begin
         e_ren = 1'b1; e_rd = p_rd; e_data = p_data; e_yen = 1'b0; e_ien = 1'b0;
         m_pend = 1'b0;
      end else if (in_valid) begin
         ldd = (in_op == 2'b11) && (in_op3 == 6'b000011);
         rd  = int'(in_rd);
         if (ldd) rd = rd - rd % 2;
         e_ren  = in_reg_write && (rd != 0);
         e_rd   = rd;
         e_data = model_data(in_op, in_op3, in_alures, in_load_data, int'(in_addr_lo));
         e_yen  = in_y_write;  e_yd  = in_y_data;
         e_ien  = in_icc_write; e_icc = in_icc;
         if (ldd) begin
            m_pend = 1'b1; p_rd = rd + 1; p_data = in_load_data[31:0];
         end
      end else begin
         e_ren = 1'b0; e_yen = 1'b0; e_ien = 1'b0;
      end
      @(negedge clk);
      compare();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " wb_reg_en"}, 64'(wb_reg_en), 64'd0);
      chk({tag, " wb_rd"}, 64'(wb_rd), 64'd0);
      chk({tag, " wb_data"}, 64'(wb_data), 64'd0);
      chk({tag, " wb_y_en"}, 64'(wb_y_en), 64'd0);
      chk({tag, " wb_y_data"}, 64'(wb_y_data), 64'd0);
      chk({tag, " wb_icc_en"}, 64'(wb_icc_en), 64'd0);
      chk({tag, " wb_icc"}, 64'(wb_icc), 64'd0);
      chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
      m_pend = 1'b0; e_ren = 1'b0; e_yen = 1'b0; e_ien = 1'b0; e_rd = 0; e_data = '0;
      f_ren = 1'b0;
   endtask

   initial begin
      logic [1:0]  op;
      logic [5:0]  op3;
      bit          ldd;
      drive(0, 2'b00, 6'd0, 0, 0, 32'd0, 64'd0, 0, 0, 32'd0, 0, 4'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset_checks("por");
      reset = 1'b0;

      drive(1, 2'b11, 6'b000001, 3, 1, 32'h0, 64'h8A1B2C3D, 0, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldub en", 64'(wb_reg_en), 64'd1);
      chk("ldub rd", 64'(wb_rd), 64'd3);
      chk("ldub data", 64'(wb_data), 64'h8A);

      drive(1, 2'b11, 6'b001010, 9, 1, 32'h0, 64'h8A1B2C3D, 2, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldsh a2 data", 64'(wb_data), 64'h2C3D);
      drive(1, 2'b11, 6'b001010, 9, 1, 32'h0, 64'h8A1B2C3D, 3, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldsh a3 data", 64'(wb_data), 64'h2C3D);
      drive(1, 2'b11, 6'b001010, 9, 1, 32'h0, 64'h1234F00D, 2, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldsh neg data", 64'(wb_data), 64'hFFFFF00D);

      drive(1, 2'b11, 6'b000011, 5, 1, 32'h0, 64'hAAAA5555_11112222, 0, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldd1 rd", 64'(wb_rd), 64'd4);
      chk("ldd1 data", 64'(wb_data), 64'hAAAA5555);
      chk("ldd1 ready", 64'(in_ready), 64'd0);
      drive(1, 2'b10, 6'd0, 7, 1, 32'hDEAD, 64'd0, 0, 1, 32'h77, 1, 4'hF);
      step();
      chk("ldd2 rd", 64'(wb_rd), 64'd5);
      chk("ldd2 data", 64'(wb_data), 64'h11112222);
      chk("ldd2 y_en", 64'(wb_y_en), 64'd0);
      chk("ldd2 ready", 64'(in_ready), 64'd1);

      drive(1, 2'b10, 6'd0, 0, 1, 32'h55, 64'd0, 0, 0, 32'd0, 1, 4'b0100);
      step();
      chk("g0 reg_en", 64'(wb_reg_en), 64'd0);
      chk("g0 icc_en", 64'(wb_icc_en), 64'd1);
      chk("g0 icc", 64'(wb_icc), 64'b0100);

      drive(1, 2'b11, 6'b000011, 0, 1, 32'h0, 64'h01020304_05060708, 0, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldd r0 first en", 64'(wb_reg_en), 64'd0);
      drive(0, 2'b00, 6'd0, 0, 0, 32'd0, 64'd0, 0, 0, 32'd0, 0, 4'd0);
      step();
      chk("ldd r0 second rd", 64'(wb_rd), 64'd1);
      chk("ldd r0 second data", 64'(wb_data), 64'h05060708);

      // Reset while the second LDD word is pending.
      drive(1, 2'b11, 6'b000011, 8, 1, 32'h0, 64'hCAFEF00D_BEEF1234, 0, 1, 32'h99, 1, 4'h3);
      step();
      drive(0, 2'b00, 6'd0, 0, 0, 32'd0, 64'd0, 0, 0, 32'd0, 0, 4'd0);
      #2 reset = 1'b1;
      #1 reset_checks("rst_ldd2");
      @(negedge clk);
      reset = 1'b0;
      reset_checks("rst_rel");
      step();
      chk("no rd+1 after reset", 64'(wb_reg_en), 64'd0);

      for (int r = 1; r <= 3; r++) begin
         drive(1, 2'b10, 6'd0, r, 1, 32'(r * 32'h1111), 64'd0, 0, 0, 32'd0, 0, 4'd0);
         step();
         chk("b2b alu data", 64'(wb_data), 64'(r * 32'h1111));
      end

      for (int i = 0; i < 3000; i++) begin
         op  = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
         op3 = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 5)] : 6'($urandom);
         ldd = (op == 2'b11) && (op3 == 6'b000011);
         drive($urandom_range(0, 3) != 0, op, op3, int'($urandom_range(0, 31)),
               ldd ? 1'b1 : 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
